fetch_queue: RTL

- Instruction queue between the IF/ID pipeline register and the decode stage.
- Captures each instruction/PC pair from the fetch stage's pipeline register exactly once.
- Buffers up to DEPTH entries and presents them in order to decode through a valid/ready handshake.
- Drives the fetch stage's no_new_fetch backpressure input and discards all contents on a taken-branch flush.

---
 rtl/fetch_queue_if.sv | 25 ++
 rtl/fetch_queue.sv | 96 +++++++++
 2 files changed

// File: rtl/fetch_queue_if.sv
// Handshake bundle between the IF/ID register, the fetch queue and decode.
// The slave side is the queue itself; the master side is the surrounding pipeline.
interface fetch_queue_if #(
  parameter int AW = 2
);
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        no_new_fetch;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready;
  logic [AW:0] count;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  no_new_fetch, out_valid, out_instr, out_pc, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output no_new_fetch, out_valid, out_instr, out_pc, count
  );
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction/PC queue between IF/ID and decode with fetch backpressure and flush.
// Define FETCHQ_BYPASS_EN to forward a push straight to the outputs when the queue is empty.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         FREEZE,
  input  logic         flush,
  fetch_queue_if.slave bus
);
  localparam logic [AW:0] L_FULL = (AW+1)'(DEPTH);

  logic [31:0]   r_instr_mem [DEPTH];
  logic [31:0]   r_pc_mem    [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;
  logic w_bypass;
  logic w_out_valid;
  logic w_wr_en;
  logic w_rd_adv;

  // Occupancy, not pointer equality, separates empty from full.
  assign w_full  = (r_count == L_FULL);
  assign w_empty = (r_count == '0);

  // Same condition under which IF advances, so each IF/ID value is taken once.
  assign w_push = bus.in_valid && !w_full && !FREEZE && !flush;

`ifdef FETCHQ_BYPASS_EN
  assign w_bypass = w_empty && w_push;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_out_valid = !w_empty || w_bypass;
  assign w_pop       = w_out_valid && bus.out_ready && !FREEZE && !flush;

  // A bypassed entry consumed in the same cycle never touches storage.
  assign w_wr_en  = w_push && !(w_bypass && w_pop);
  assign w_rd_adv = w_pop && !w_bypass;

  assign bus.no_new_fetch = w_full;
  assign bus.out_valid    = w_out_valid;
  assign bus.count        = r_count;

  always_comb begin
    bus.out_instr = 32'h0000_0000;
    bus.out_pc    = 32'h0000_0000;
    if (w_bypass) begin
      bus.out_instr = bus.in_instr;
      bus.out_pc    = bus.in_pc;
    end else if (!w_empty) begin
      bus.out_instr = r_instr_mem[r_rd_ptr];
      bus.out_pc    = r_pc_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET && w_wr_en) begin
      r_instr_mem[r_wr_ptr] <= bus.in_instr;
      r_pc_mem[r_wr_ptr]    <= bus.in_pc;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (!FREEZE) begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_adv) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_en, w_rd_adv})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule
